// File: rtl/morse_decoder.sv
// morse_decoder: deserialises a 12-bit Morse frame and maps it to letter codes A-H (0-7)
module morse_decoder #(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       Clear,
  input  logic       DotDashIn,
  input  logic       NewBitIn,
  output logic [2:0] Letter,
  output logic       Valid,
  output logic       Error,
  output logic       Busy
);
  localparam int TW = $clog2(CLOCK_FREQUENCY) + 1;
  localparam logic [TW-1:0] T_MAX = TW'(CLOCK_FREQUENCY - 1);
  localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, DECODE = 2'd2;
  localparam logic [95:0] TABLE = {
    12'b101010100000, 12'b111011101000, 12'b101011101000, 12'b100000000000,
    12'b111010100000, 12'b111010111010, 12'b111010101000, 12'b101110000000};
  logic [1:0]    state;
  logic [11:0]   frame;
  logic [3:0]    bit_count;
  logic [TW-1:0] t_count;
  logic          hit;
  logic [2:0]    idx;
  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (frame == TABLE[i*12 +: 12]) begin
        hit = 1'b1;
        idx = 3'(i);
      end
  end
  assign Busy = state != IDLE;
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      frame     <= '0;
      bit_count <= '0;
      t_count   <= '0;
      Letter    <= '0;
      Valid     <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Valid <= 1'b0;
      Error <= 1'b0;
      if (Clear) begin
        state     <= IDLE;
        bit_count <= '0;
        t_count   <= '0;
      end else begin
        case (state)
          IDLE: if (NewBitIn && DotDashIn) begin
            frame     <= 12'd1;
            bit_count <= 4'd1;
            t_count   <= '0;
            state     <= RECV;
          end
          RECV: if (t_count == T_MAX) begin
            Error <= 1'b1;
            state <= IDLE;
          end else if (NewBitIn) begin
            frame     <= {frame[10:0], DotDashIn};
            bit_count <= bit_count + 4'd1;
            t_count   <= '0;
            if (bit_count == 4'd11) state <= DECODE;
          end else begin
            t_count <= t_count + 1'b1;
          end
          DECODE: begin
            state <= IDLE;
            if (hit) begin
              Letter <= idx;
              Valid  <= 1'b1;
            end else begin
              Error <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed frames with a scoreboard queue checked by a pulse monitor
module tb_morse_decoder;
  logic       ClockIn = 1'b0;
  logic       Resetn, Clear, DotDashIn, NewBitIn;
  logic [2:0] Letter;
  logic       Valid, Error, Busy;
  int         total = 0;
  int         bad = 0;
  bit         exp_err[$];
  logic [2:0] exp_let[$];
  localparam logic [11:0] CODES [8] = '{
    12'b101110000000, 12'b111010101000, 12'b111010111010, 12'b111010100000,
    12'b100000000000, 12'b101011101000, 12'b111011101000, 12'b101010100000};

  morse_decoder #(.CLOCK_FREQUENCY(500)) dut (
    .ClockIn(ClockIn), .Resetn(Resetn), .Clear(Clear), .DotDashIn(DotDashIn),
    .NewBitIn(NewBitIn), .Letter(Letter), .Valid(Valid), .Error(Error), .Busy(Busy));

  always #5 ClockIn = ~ClockIn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge ClockIn);
    #1;
  endtask

  task automatic push(input bit e, input logic [2:0] l);
    exp_err.push_back(e);
    exp_let.push_back(l);
  endtask

  task automatic send_bits(input logic [11:0] code, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      NewBitIn  = 1'b1;
      DotDashIn = code[11-i];
      tick;
      NewBitIn  = 1'b0;
      if (i < n - 1) repeat (gap - 1) tick;
    end
  endtask

  always @(negedge ClockIn) begin
    if (Valid || Error) begin
      chk("pulse_exclusive", 32'(Valid && Error), 0);
      chk("busy_at_pulse", 32'(Busy), 0);
      if (exp_err.size() == 0) begin
        chk("unexpected_pulse", 32'({Valid, Error}), 0);
      end else begin
        chk("pulse_kind_error", 32'(Error), 32'(exp_err[0]));
        chk("pulse_letter", 32'(Letter), 32'(exp_let[0]));
        void'(exp_err.pop_front());
        void'(exp_let.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Resetn = 1'b0; Clear = 1'b0; NewBitIn = 1'b0; DotDashIn = 1'b0;
    repeat (3) tick;
    chk("reset_outputs", 32'({Letter, Valid, Error, Busy}), 0);
    Resetn = 1'b1;
    tick;
    send_bits(CODES[3], 5, 1);
    chk("busy_mid_stream", 32'(Busy), 1);
    Resetn = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({Letter, Valid, Error, Busy}), 0);
    tick;
    Resetn = 1'b1;
    tick;
    push(1'b0, 3'd0);
    send_bits(CODES[0], 12, 250);
    chk("e12_busy", 32'(Busy), 1);
    chk("e12_valid", 32'(Valid), 0);
    tick;
    chk("e12p1_valid", 32'(Valid), 1);
    chk("e12p1_letter", 32'(Letter), 0);
    chk("e12p1_busy", 32'(Busy), 0);
    tick;
    chk("valid_one_cycle", 32'(Valid), 0);
    for (int k = 0; k < 8; k++) begin
      send_bits(12'h000, 1, 1);
      push(1'b0, 3'(k));
      send_bits(CODES[k], 12, 1);
      tick;
      chk("sweep_letter", 32'(Letter), 32'(k));
      tick;
    end
    push(1'b1, 3'd7);
    send_bits(12'hC00, 12, 1);
    tick;
    chk("bad_error", 32'(Error), 1);
    chk("bad_valid", 32'(Valid), 0);
    chk("bad_letter_held", 32'(Letter), 7);
    tick;
    push(1'b1, 3'd7);
    send_bits(12'hB00, 4, 3);
    repeat (499) tick;
    chk("timeout_not_yet", 32'(Error), 0);
    chk("timeout_busy_before", 32'(Busy), 1);
    tick;
    chk("timeout_error", 32'(Error), 1);
    chk("timeout_busy_after", 32'(Busy), 0);
    tick;
    chk("timeout_single_pulse", 32'(Error), 0);
    push(1'b0, 3'd4);
    send_bits(CODES[4], 12, 2);
    tick;
    tick;
    chk("after_timeout_letter", 32'(Letter), 4);
    send_bits(CODES[1], 6, 1);
    Clear = 1'b1; NewBitIn = 1'b1; DotDashIn = 1'b1;
    tick;
    Clear = 1'b0; NewBitIn = 1'b0;
    chk("clear_busy", 32'(Busy), 0);
    repeat (5) tick;
    chk("clear_stays_idle", 32'(Busy), 0);
    push(1'b0, 3'd2);
    send_bits(CODES[2], 12, 1);
    tick;
    tick;
    chk("after_clear_letter", 32'(Letter), 2);
    send_bits(CODES[5], 9, 2);
    Resetn = 1'b0;
    #1;
    chk("midframe_reset_letter", 32'(Letter), 0);
    chk("midframe_reset_busy", 32'(Busy), 0);
    repeat (2) tick;
    Resetn = 1'b1;
    tick;
    push(1'b0, 3'd6);
    send_bits(CODES[6], 12, 1);
    tick;
    tick;
    chk("after_reset_letter", 32'(Letter), 6);
    repeat (5) tick;
    chk("scoreboard_drained", 32'(exp_err.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
